serial_tx_sched: RTL

SERIAL_TX_SCHED -- requirements
Module: serial_tx_sched

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_tx_shifter.sv | 41 ++++
 rtl/serial_tx_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit scheduler.
// SERIAL_TX_PARITY_EN adds the PARITY state between DATA and STOP.
package serial_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_e;

endpackage

// File: rtl/serial_tx_shifter.sv
// Byte holding register: loads on grant, shifts LSB-first, keeps odd parity.
// SERIAL_TX_PARITY_EN exposes the parity bit.
module serial_tx_shifter
    import serial_pkg::*;
(
    input  logic                 clk,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 shift_i,
`ifdef SERIAL_TX_PARITY_EN
    output logic                 parity_o,
`endif
    output logic                 bit_o
);

    logic [DATA_BITS-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (load_i) begin
            sh_q <= data_i;
        end else if (shift_i) begin
            sh_q <= {1'b0, sh_q[DATA_BITS-1:1]};
        end
    end

    assign bit_o = sh_q[0];

`ifdef SERIAL_TX_PARITY_EN
    logic par_q;

    // Odd parity: computed once at load so shifting cannot disturb it.
    always_ff @(posedge clk) begin
        if (load_i) begin
            par_q <= ~^data_i;
        end
    end

    assign parity_o = par_q;
`endif

endmodule

// File: rtl/serial_tx_sched.sv
// Round-robin byte arbiter feeding a registered UART-style serial framer.
// SERIAL_TX_PARITY_EN inserts an odd-parity bit after the data bits.
module serial_tx_sched
    import serial_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 ser_out,
    input  logic                 rx_done,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 frame_err,
    output logic [15:0]          tx_count
);

    state_e       state_q, state_d;
    logic [2:0]   last_q, last_d, gid_q, gid_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ack_q, ack_d, ser_q, ser_d, err_q, err_d;
    logic [15:0]  txc_q, txc_d;

    logic [3:0]         rr_sh;
    logic [NUM_REQ-1:0] rr_rot, rr_low, rr_win;
    logic [7:0]         rr_win8;
    logic [2:0]         win_idx;
    logic [7:0]         win_byte;
    logic               xfer, shift, sh_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic               sh_par;
`endif

    // Rotate so the search starts at last+1, isolate lowest set bit, rotate back.
    assign rr_sh    = {1'b0, last_q} + 4'd1;
    assign rr_rot   = NUM_REQ'({req_valid, req_valid} >> rr_sh);
    assign rr_low   = rr_rot & (-rr_rot);
    assign rr_win   = NUM_REQ'(({rr_low, rr_low} << rr_sh) >> NUM_REQ);
    assign rr_win8  = 8'(rr_win);
    assign win_idx  = {|(rr_win8 & 8'hF0), |(rr_win8 & 8'hCC), |(rr_win8 & 8'hAA)};
    assign win_byte = 8'(64'(req_data) >> {win_idx, 3'b000});

    assign req_ready = (state_q == IDLE && !rst) ? rr_win : '0;
    assign xfer      = |(req_valid & req_ready);

    serial_tx_shifter u_shifter (
        .clk      (clk),
        .load_i   (xfer),
        .data_i   (win_byte),
        .shift_i  (shift),
`ifdef SERIAL_TX_PARITY_EN
        .parity_o (sh_par),
`endif
        .bit_o    (sh_bit)
    );

    // ser_d is the bit for the state being entered, so ser_out lines up with state.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        ser_d   = STOP_BIT;
        err_d   = 1'b0;
        txc_d   = txc_q;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                    last_d  = win_idx;
                    gid_d   = win_idx;
                    ack_d   = 1'b0;
                    ser_d   = START_BIT;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                ser_d   = sh_bit;
                shift   = 1'b1;
            end
            DATA: begin
                if (cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PARITY;
                    ser_d   = sh_par;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    ser_d = sh_bit;
                    shift = 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            STOP: begin
                state_d = GAP;
                cnt_d   = '0;
                ack_d   = ack_q | rx_done;
            end
            GAP: begin
                ack_d = ack_q | rx_done;
                if (cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    txc_d   = txc_q + 16'd1;
                    err_d   = ~(ack_q | rx_done);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 3'(NUM_REQ - 1);
            gid_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            ser_q   <= STOP_BIT;
            err_q   <= 1'b0;
            txc_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            ser_q   <= ser_d;
            err_q   <= err_d;
            txc_q   <= txc_d;
        end
    end

    assign ser_out   = ser_q;
    assign grant_id  = gid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = err_q;
    assign tx_count  = txc_q;

endmodule
